alu_cmd_sequencer: RTL

Command-side initiator for the 32-bit ALU. It accepts one operation at a time over a valid/ready command channel and drives the ALU's `op1`/`op2`/`alu_control` inputs from registers. After a programmable settle time it captures the ALU's `result`/`zero`, keeps the result in an accumulator, and returns it over a valid/ready response channel. It sits between instruction-issue logic and the combinational ALU, so upstream logic never touches the ALU ports directly.

---
 rtl/alu_cmd_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: single-outstanding command sequencer in front of the
// combinational 32-bit ALU. Registers the ALU operands/opcode, waits a
// programmable settle time, captures result/zero into a response register
// and an accumulator, and returns the response over a valid/ready channel.
module alu_cmd_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic        cmd_use_acc,
  output logic [31:0] alu_op1,
  output logic [31:0] alu_op2,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err,
  output logic [31:0] acc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter reload: capture happens when the counter has reached zero, so
  // loading SETTLE_CYCLES-1 holds the ALU inputs for SETTLE_CYCLES cycles.
  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [3:0] settle_cnt;

  logic load_cmd;
  logic load_err;
  logic capture;
  logic cnt_dec;

  // State register; reset always returns to IDLE, discarding any command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus handshake outputs and datapath strobes.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    rsp_valid  = 1'b0;
    load_cmd   = 1'b0;
    load_err   = 1'b0;
    capture    = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = ~rst;
        if (cmd_valid && !rst) begin
          if (cmd_op[3]) begin
            load_err   = 1'b1;
            state_next = RESP;
          end else begin
            load_cmd   = 1'b1;
            state_next = EXEC;
          end
        end
      end
      EXEC: begin
        if (settle_cnt == 4'd0) begin
          capture    = 1'b1;
          state_next = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ALU port registers and settle counter; operands only move on a legal accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op1     <= '0;
      alu_op2     <= '0;
      alu_control <= '0;
      settle_cnt  <= '0;
    end else begin
      if (load_cmd) begin
        alu_op1     <= cmd_use_acc ? acc : cmd_a;
        alu_op2     <= cmd_b;
        alu_control <= cmd_op;
        settle_cnt  <= SETTLE_INIT;
      end else if (cnt_dec) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
    end
  end

  // Response fields and accumulator; written only on entry to RESP so they
  // stay stable while the response waits for rsp_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      acc        <= '0;
    end else begin
      if (load_err) begin
        rsp_result <= '0;
        rsp_zero   <= 1'b0;
        rsp_err    <= 1'b1;
      end else if (capture) begin
        rsp_result <= alu_result;
        rsp_zero   <= alu_zero;
        rsp_err    <= 1'b0;
        acc        <= alu_result;
      end
    end
  end

endmodule
